seq_scan_ctrl: RTL

- Word-level controller for the team's serial "1001" Moore sequence detector.
- Accepts a parallel word over a valid/ready handshake and feeds it to the detector one bit per clock, MSB first.
- Counts detections and records the bit index of the first detection in the word.
- Returns a result record over a second valid/ready handshake. Sits between a parallel producer and the bit-serial detector.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_det_1001.sv | 32 +++
 rtl/seq_scan_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the word-level "1001" scan controller and its
// bit-serial Moore detector.
package seq_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } det_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/seq_det_1001.sv
// Bit-serial Moore detector for "1001"; hit is asserted while in S4, i.e. one
// cycle after the completing bit. Holds its state whenever en is low.
module seq_det_1001
  import seq_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic bit_in,
  output logic hit
);

  det_state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S0;
    end else if (en) begin
      case (state)
        S0:      state <= bit_in ? S1 : S0;
        S1:      state <= bit_in ? S1 : S2;
        S2:      state <= bit_in ? S1 : S3;
        S3:      state <= bit_in ? S4 : S0;
        S4:      state <= bit_in ? S1 : S0;
        default: state <= S0;
      endcase
    end
  end

  assign hit = (state == S4);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-level controller: accepts a parallel word, streams it MSB first through
// the "1001" detector, and returns detection count / first-hit index.
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 4,
  parameter int IDX_W = $clog2(W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_word,
  input  logic             in_cont,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_first_idx
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(W - 1);

  ctrl_state_t      state;
  logic [W-1:0]     shreg;
  logic [IDX_W-1:0] j;
  logic             accept;
  logic             det_rst;
  logic             det_en;
  logic             det_hit;
  logic             take;
  logic [IDX_W-1:0] take_idx;

  assign accept    = (state == IDLE) && in_valid;
  assign det_rst   = reset || (accept && !in_cont);
  assign det_en    = (state == SHIFT);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  seq_det_1001 u_det (
    .clock  (clock),
    .reset  (det_rst),
    .en     (det_en),
    .bit_in (shreg[W-1]),
    .hit    (det_hit)
  );

  // The detector's hit lags its input by one cycle: a hit seen at j belongs
  // to bit j-1, and the hit seen at j=0 was already counted by the previous
  // word's DRAIN cycle.
  always_comb begin
    take     = 1'b0;
    take_idx = '0;
    if (state == SHIFT && det_hit && j != '0) begin
      take     = 1'b1;
      take_idx = j - 1'b1;
    end else if (state == DRAIN && det_hit) begin
      take     = 1'b1;
      take_idx = LAST;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      j             <= '0;
      out_count     <= '0;
      out_hit       <= 1'b0;
      out_first_idx <= '0;
    end else begin
      if (take) begin
        if (out_count != CNT_MAX) out_count <= out_count + 1'b1;
        if (!out_hit) begin
          out_hit       <= 1'b1;
          out_first_idx <= take_idx;
        end
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg         <= in_word;
            j             <= '0;
            out_count     <= '0;
            out_hit       <= 1'b0;
            out_first_idx <= '0;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= shreg << 1;
          j     <= j + 1'b1;
          if (j == LAST) state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE:  if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
